processor_stage2: RTL and testbench

Decode/branch stage of the asm18 pipeline. It sits directly after the fetch stage and consumes that stage's outputs (`no_operation`, `ip`, `ip_plus_one`) together with the code word returned by program memory. It resolves control-flow instructions (JMP, JZ, JNZ, CALL, RET) and drives the `ip_to_call`/`call_performed` redirect back into fetch. It owns a small hardware return-address stack and forwards the non-branch instruction stream to stage 3.

---
 rtl/processor_stage2_pkg.sv | 23 ++
 rtl/processor_stage2_if.sv | 31 +++
 rtl/processor_stage2_return_stack.sv | 58 +++++
 rtl/processor_stage2.sv | 104 ++++++++++
 tb/tb_processor_stage2.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/processor_stage2_pkg.sv
// Shared asm18 decode definitions.
// Holds the opcode constants and the opcode/immediate field positions used by
// the decode/branch stage and the later decode/execute stages.
package processor_defs;

    localparam int OP_MSB  = 17;
    localparam int OP_LSB  = 14;
    localparam int IMM_MSB = 13;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_JNZ  = 4'h3;
    localparam logic [3:0] OP_CALL = 4'h4;
    localparam logic [3:0] OP_RET  = 4'h5;

    // True for every opcode that this stage consumes as a control-flow instruction.
    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JNZ) ||
               (op == OP_CALL) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/processor_stage2_if.sv
// Pipeline bus around the decode/branch stage.
// Fetch-side inputs (bubble flag, ip, fall-through ip, code word), the redirect
// back to fetch (ip_to_call, call_performed) and the registered stream to
// stage 3 (no_operation_out, instr_out, ip_plus_one_out).
// master: the surrounding pipeline; slave: processor_stage2.
interface processor_stage2_if #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18
);
    logic                 no_operation_in;
    logic [ADDR_SIZE-1:0] ip_in;
    logic [ADDR_SIZE-1:0] ip_plus_one_in;
    logic [WORD_SIZE-1:0] code_word;
    logic [WORD_SIZE-1:0] ip_to_call;
    logic                 call_performed;
    logic                 no_operation_out;
    logic [WORD_SIZE-1:0] instr_out;
    logic [ADDR_SIZE-1:0] ip_plus_one_out;

    modport master (
        output no_operation_in, ip_in, ip_plus_one_in, code_word,
        input  ip_to_call, call_performed,
        input  no_operation_out, instr_out, ip_plus_one_out
    );

    modport slave (
        input  no_operation_in, ip_in, ip_plus_one_in, code_word,
        output ip_to_call, call_performed,
        output no_operation_out, instr_out, ip_plus_one_out
    );
endinterface

// File: rtl/processor_stage2_return_stack.sv
// Hardware return-address stack: circular buffer of STACK_DEPTH entries.
// Ports: clock, reset (async active-low), push/pop requests, push_data,
// top (current top of stack, 0 when empty), empty, full.
// sp points at the next free slot, so the top lives at sp-1. When full, sp
// points at the oldest entry, so an overflowing push overwrites exactly that one.
module return_stack #(
    parameter int ADDR_SIZE   = 18,
    parameter int STACK_DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ADDR_SIZE-1:0] push_data,
    output logic [ADDR_SIZE-1:0] top,
    output logic                 empty,
    output logic                 full
);
    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [PTR_W-1:0]     sp_reg;
    logic [PTR_W:0]       count_reg;
    logic [ADDR_SIZE-1:0] entry_reg [STACK_DEPTH];
    logic [PTR_W-1:0]     top_idx;

    assign top_idx = sp_reg - PTR_W'(1);
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(STACK_DEPTH));
    assign top     = empty ? '0 : entry_reg[top_idx];

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    entry_reg[gi] <= '0;
                end else if (push && (sp_reg == PTR_W'(gi))) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp_reg    <= '0;
            count_reg <= '0;
        end else if (push) begin
            sp_reg <= sp_reg + PTR_W'(1);
            if (!full) begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            // Underflowing pop leaves sp where it is.
            sp_reg    <= sp_reg - PTR_W'(1);
            count_reg <= count_reg - (PTR_W+1)'(1);
        end
    end
endmodule

// File: rtl/processor_stage2.sv
// Decode/branch stage of the asm18 pipeline.
// Ports: clock, reset (async active-low), zero_flag (from execute),
// bus (slave side of processor_stage2_if: fetch inputs, redirect to fetch,
// registered stream to stage 3), stack_error (sticky over/underflow flag).
// Control-flow instructions are resolved and consumed here; everything else
// is forwarded to stage 3 one cycle later.
module processor_stage2
    import processor_defs::*;
#(
    parameter int ADDR_SIZE   = 18,
    parameter int WORD_SIZE   = 18,
    parameter int STACK_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  zero_flag,
    processor_stage2_if.slave     bus,
    output logic                  stack_error
);
    logic [3:0]           opcode;
    logic [ADDR_SIZE-1:0] imm;
    logic                 slot_valid;
    logic                 is_branch;
    logic                 taken;
    logic                 do_push;
    logic                 do_pop;
    logic [ADDR_SIZE-1:0] stack_top;
    logic                 stack_empty;
    logic                 stack_full;
    logic [ADDR_SIZE-1:0] target;

    logic                 no_operation_reg;
    logic [WORD_SIZE-1:0] instr_reg;
    logic [ADDR_SIZE-1:0] ip_plus_one_reg;
    logic                 stack_error_reg;

    assign opcode = bus.code_word[OP_MSB:OP_LSB];
    assign imm    = ADDR_SIZE'(bus.code_word[IMM_MSB:IMM_LSB]);

    // Gating with reset keeps the redirect quiet while the pipeline is held in reset.
    assign slot_valid = !bus.no_operation_in && reset;
    assign is_branch  = is_branch_op(opcode);
    assign do_push    = slot_valid && (opcode == OP_CALL);
    assign do_pop     = slot_valid && (opcode == OP_RET);

    always_comb begin
        taken  = 1'b0;
        target = imm;
        unique case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = zero_flag;
            OP_JNZ:  taken = !zero_flag;
            OP_CALL: taken = 1'b1;
            OP_RET: begin
                taken  = 1'b1;
                target = stack_top;   // already 0 when the stack is empty
            end
            default: taken = 1'b0;
        endcase
        if (!slot_valid) begin
            taken = 1'b0;
        end
        bus.call_performed = taken;
        bus.ip_to_call     = taken ? WORD_SIZE'(target) : '0;
    end

    return_stack #(
        .ADDR_SIZE   (ADDR_SIZE),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (bus.ip_plus_one_in),
        .top       (stack_top),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            no_operation_reg <= 1'b1;
            instr_reg        <= '0;
            ip_plus_one_reg  <= '0;
            stack_error_reg  <= 1'b0;
        end else begin
            // Branches are consumed here, so only valid non-branches reach stage 3.
            no_operation_reg <= !(slot_valid && !is_branch);
            if (slot_valid && !is_branch) begin
                instr_reg       <= bus.code_word;
                ip_plus_one_reg <= bus.ip_plus_one_in;
            end
            if ((do_push && stack_full) || (do_pop && stack_empty)) begin
                stack_error_reg <= 1'b1;
            end
        end
    end

    assign bus.no_operation_out = no_operation_reg;
    assign bus.instr_out        = instr_reg;
    assign bus.ip_plus_one_out  = ip_plus_one_reg;
    assign stack_error          = stack_error_reg;
endmodule

// File: tb/tb_processor_stage2.sv
module tb_processor_stage2;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic zero_flag = 1'b0;
    logic stack_error;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic        nop;
        logic [17:0] instr;
        logic [17:0] ipp1;
    } fwd_t;

    fwd_t        exp_q[$];
    logic [17:0] model_instr = '0;
    logic [17:0] model_ipp1  = '0;

    processor_stage2_if #(.ADDR_SIZE(18), .WORD_SIZE(18)) bus ();

    processor_stage2 #(.ADDR_SIZE(18), .WORD_SIZE(18), .STACK_DEPTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .zero_flag   (zero_flag),
        .bus         (bus.slave),
        .stack_error (stack_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [13:0] imm);
        return {op, imm};
    endfunction

    // One pipeline slot: check the redirect in-cycle, queue the expected
    // stage-3 outputs, then compare them after the edge.
    task automatic slot(input string tag, input logic nop, input logic [17:0] ip,
                        input logic [17:0] ipp1, input logic [17:0] code, input logic zf,
                        input logic exp_cp, input logic [17:0] exp_tgt);
        logic [3:0] op;
        fwd_t       e;
        fwd_t       got;
        @(negedge clock);
        bus.no_operation_in = nop;
        bus.ip_in           = ip;
        bus.ip_plus_one_in  = ipp1;
        bus.code_word       = code;
        zero_flag           = zf;
        #1;
        check({tag, " call_performed"}, 32'(bus.call_performed), 32'(exp_cp));
        check({tag, " ip_to_call"}, 32'(bus.ip_to_call), 32'(exp_tgt));
        op = code[17:14];
        if (!nop && !(op >= 4'h1 && op <= 4'h5)) begin
            model_instr = code;
            model_ipp1  = ipp1;
            e = '{nop: 1'b0, instr: model_instr, ipp1: model_ipp1};
        end else begin
            e = '{nop: 1'b1, instr: model_instr, ipp1: model_ipp1};
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            got = '{nop: bus.no_operation_out, instr: bus.instr_out, ipp1: bus.ip_plus_one_out};
            check({tag, " no_operation_out"}, 32'(got.nop), 32'(e.nop));
            check({tag, " instr_out"}, 32'(got.instr), 32'(e.instr));
            check({tag, " ip_plus_one_out"}, 32'(got.ipp1), 32'(e.ipp1));
        end
    endtask

    initial begin
        // Reset with random inputs.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.no_operation_in = 1'($urandom);
            bus.ip_in           = 18'($urandom);
            bus.ip_plus_one_in  = 18'($urandom);
            bus.code_word       = 18'($urandom);
            zero_flag           = 1'($urandom);
            #1;
            check("reset no_operation_out", 32'(bus.no_operation_out), 32'd1);
            check("reset instr_out", 32'(bus.instr_out), 32'd0);
            check("reset call_performed", 32'(bus.call_performed), 32'd0);
            check("reset stack_error", 32'(stack_error), 32'd0);
        end
        @(negedge clock);
        bus.no_operation_in = 1'b1;
        bus.code_word       = '0;
        reset = 1'b1;

        // Unconditional and conditional branches.
        slot("jmp", 0, 18'd5, 18'd6, mk(4'h1, 14'h0100), 0, 1, 18'h00100);
        slot("jz nt", 0, 18'd6, 18'd7, mk(4'h2, 14'h20), 0, 0, 18'h0);
        slot("jz t", 0, 18'd7, 18'd8, mk(4'h2, 14'h20), 1, 1, 18'h20);
        slot("jnz nt", 0, 18'd8, 18'd9, mk(4'h3, 14'h30), 1, 0, 18'h0);
        slot("jnz t", 0, 18'd9, 18'd10, mk(4'h3, 14'h30), 0, 1, 18'h30);

        // CALL, ADD, RET.
        slot("call", 0, 18'h10, 18'h11, mk(4'h4, 14'h40), 0, 1, 18'h40);
        slot("add", 0, 18'h40, 18'h41, mk(4'h6, 14'h123), 0, 0, 18'h0);
        slot("ret", 0, 18'h41, 18'h42, mk(4'h5, 14'h0), 0, 1, 18'h11);

        // Back-to-back CALL then RET.
        slot("call b2b", 0, 18'h20, 18'h21, mk(4'h4, 14'h50), 0, 1, 18'h50);
        slot("ret b2b", 0, 18'h50, 18'h51, mk(4'h5, 14'h0), 0, 1, 18'h21);

        // Bubble carrying a RET must not pop.
        slot("call pre-bubble", 0, 18'h30, 18'h31, mk(4'h4, 14'h60), 0, 1, 18'h60);
        slot("bubble ret", 1, 18'h60, 18'h61, mk(4'h5, 14'h0), 0, 0, 18'h0);
        slot("ret post-bubble", 0, 18'h61, 18'h62, mk(4'h5, 14'h0), 0, 1, 18'h31);
        check("stack_error before overflow", 32'(stack_error), 32'd0);

        // Nine nested CALLs overflow the 8-entry stack.
        for (int i = 0; i < 9; i++) begin
            slot($sformatf("call nest %0d", i), 0, 18'(18'h100 + i), 18'(18'h101 + i),
                 mk(4'h4, 14'h200), 0, 1, 18'h200);
            if (i == 7) check("stack_error at 8 calls", 32'(stack_error), 32'd0);
        end
        check("stack_error after 9th call", 32'(stack_error), 32'd1);
        for (int i = 8; i >= 1; i--) begin
            slot($sformatf("ret nest %0d", i), 0, 18'h200, 18'h201,
                 mk(4'h5, 14'h0), 0, 1, 18'(18'h101 + i));
        end
        slot("ret underflow", 0, 18'h200, 18'h201, mk(4'h5, 14'h0), 0, 1, 18'h0);
        check("stack_error sticky", 32'(stack_error), 32'd1);

        // Forwarding after the stack activity.
        slot("sub", 0, 18'h300, 18'h301, mk(4'h9, 14'h3ff), 0, 0, 18'h0);

        // Reset clears the sticky error.
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset clears stack_error", 32'(stack_error), 32'd0);
        check("reset clears instr_out", 32'(bus.instr_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
